// File: rtl/debug_uart_pkg.sv
// ---------------------------------------------------------------------------
// debug_uart_pkg : shared constants, byte-FSM encoding and checksum helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debug_uart_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_BYTES       = 9;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    // Element [i] holds debug_port(i+1).
    typedef logic [6:0][7:0] port_bytes_t;

    function automatic logic [7:0] calc_checksum(input port_bytes_t b);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < 7; i++) begin
            sum = sum + b[i];
        end
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte : 8N1 byte serializer with 16-bit baud down-counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_byte
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q,   state_d;
    logic [15:0] baud_q,    baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,   shift_d;
    logic        tx_q,      tx_d;
    logic        bit_end;

    assign bit_end = (baud_q == 16'd0);
    // Accepting a byte in the last stop-bit cycle keeps bytes back-to-back.
    assign ready   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
    assign tx      = tx_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        if (ready && load) begin
            state_d   = ST_START;
            shift_d   = data_in;
            baud_d    = BAUD_RELOAD;
            bit_idx_d = 3'd0;
            tx_d      = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (!bit_end) begin
                baud_d = baud_q - 16'd1;
            end else begin
                baud_d = BAUD_RELOAD;
                case (state_q)
                    ST_START: begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                    ST_DATA: begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            tx_d      = shift_q[0];
                            shift_d   = {1'b0, shift_q[7:1]};
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_port_uart_tx.sv
// ---------------------------------------------------------------------------
// debug_port_uart_tx : snapshots seven debug ports per trigger, sends framed
// Revision: 1.0        packet SYNC, port1..7, CHK over 8N1 UART
// ---------------------------------------------------------------------------
`default_nettype none

module debug_port_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    input  logic       trigger,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_count
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    port_bytes_t snap_q,       snap_d;
    logic [7:0]  chk_q,        chk_d;
    logic [3:0]  byte_idx_q,   byte_idx_d;
    logic        busy_q,       busy_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  overrun_q,    overrun_d;

    port_bytes_t ports_in;
    logic [7:0]  frame_bytes [0:FRAME_BYTES-1];
    logic [3:0]  next_idx;
    logic        byte_load;
    logic        byte_ready;
    logic [7:0]  byte_data;

    assign ports_in = {debug_port7, debug_port6, debug_port5, debug_port4,
                       debug_port3, debug_port2, debug_port1};
    assign next_idx = byte_idx_q + 4'd1;

    always_comb begin
        frame_bytes[0] = SYNC_BYTE;
        for (int i = 0; i < 7; i++) begin
            frame_bytes[i+1] = snap_q[i];
        end
        frame_bytes[FRAME_BYTES-1] = chk_q;
    end

    always_comb begin
        snap_d       = snap_q;
        chk_d        = chk_q;
        byte_idx_d   = byte_idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        byte_load    = 1'b0;
        byte_data    = SYNC_BYTE;
        if (!busy_q) begin
            if (trigger) begin
                snap_d     = ports_in;
                chk_d      = calc_checksum(ports_in);
                byte_idx_d = 4'd0;
                busy_d     = 1'b1;
                byte_load  = 1'b1;
            end
        end else begin
            if (trigger && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
            if (byte_ready) begin
                if (byte_idx_q < LAST_BYTE) begin
                    byte_load  = 1'b1;
                    byte_idx_d = next_idx;
                    byte_data  = frame_bytes[next_idx];
                end else begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            snap_q       <= '0;
            chk_q        <= 8'h00;
            byte_idx_q   <= 4'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 8'h00;
        end else begin
            snap_q       <= snap_d;
            chk_q        <= chk_d;
            byte_idx_q   <= byte_idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .nreset  (nreset),
        .load    (byte_load),
        .data_in (byte_data),
        .ready   (byte_ready),
        .tx      (tx)
    );

    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign overrun_count = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_port_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_debug_port_uart_tx : directed bench with per-cycle frame model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debug_port_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 90 * CPB;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       trigger = 1'b0;
    logic [7:0] dp [7];
    logic       tx, busy, frame_done;
    logic [7:0] overrun_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    debug_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .debug_port1   (dp[0]),
        .debug_port2   (dp[1]),
        .debug_port3   (dp[2]),
        .debug_port4   (dp[3]),
        .debug_port5   (dp[4]),
        .debug_port6   (dp[5]),
        .debug_port7   (dp[6]),
        .trigger       (trigger),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_count (overrun_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model: a frame is a list of line levels, one per bit time, built from the bytes.
    int         rem = 0;
    bit         fbits[$];
    logic [7:0] fb [9];
    logic [7:0] sum;
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_fd   = 1'b0;
    logic [7:0] exp_ovr  = 8'h00;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rem     = 0;
            exp_fd  = 1'b0;
            exp_ovr = 8'h00;
        end else begin
            exp_fd = 1'b0;
            if (rem > 0) begin
                if (trigger && exp_ovr != 8'hFF) exp_ovr = exp_ovr + 8'd1;
                rem = rem - 1;
                if (rem == 0) exp_fd = 1'b1;
            end else if (trigger) begin
                fb[0] = 8'hA5;
                sum   = 8'h00;
                for (int k = 0; k < 7; k++) begin
                    fb[k+1] = dp[k];
                    sum     = sum + dp[k];
                end
                fb[8] = sum;
                fbits.delete();
                for (int k = 0; k < 9; k++) begin
                    fbits.push_back(1'b0);
                    for (int j = 0; j < 8; j++) fbits.push_back(fb[k][j]);
                    fbits.push_back(1'b1);
                end
                rem = FRAME_CYC;
            end
        end
        exp_busy = (rem > 0);
        exp_tx   = (rem > 0) ? fbits[(FRAME_CYC - rem) / CPB] : 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_tx",         {31'd0, tx},         {31'd0, exp_tx});
            check("cyc_busy",       {31'd0, busy},       {31'd0, exp_busy});
            check("cyc_frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            check("cyc_overrun",    {24'd0, overrun_count}, {24'd0, exp_ovr});
        end
    end

    logic [7:0] got [9];
    int         busy_cyc;
    int         fd_cnt;

    // Pulses trigger, optionally corrupts the ports afterwards, decodes the line.
    task automatic run_frame(input bit ff_after);
        int b;
        for (int k = 0; k < 9; k++) got[k] = 8'h00;
        busy_cyc = 0;
        fd_cnt   = 0;
        @(posedge clk); #2 trigger = 1'b1;
        @(posedge clk); #2 trigger = 1'b0;
        if (ff_after) for (int k = 0; k < 7; k++) dp[k] = 8'hFF;
        for (int i = 0; i < FRAME_CYC + 5; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (frame_done) fd_cnt++;
            if (i < FRAME_CYC && (i % CPB) == 2) begin
                b = i / CPB;
                if ((b % 10) >= 1 && (b % 10) <= 8) got[b / 10][(b % 10) - 1] = tx;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] e1, input logic [7:0] step,
                               input logic [7:0] echk);
        logic [7:0] e;
        check({name, "_sync"}, {24'd0, got[0]}, 32'hA5);
        e = e1;
        for (int k = 1; k <= 7; k++) begin
            check({name, "_data"}, {24'd0, got[k]}, {24'd0, e});
            e = e + step;
        end
        check({name, "_chk"}, {24'd0, got[8]}, {24'd0, echk});
        check({name, "_busy_cycles"}, busy_cyc, FRAME_CYC);
        check({name, "_done_pulses"}, fd_cnt, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic pulse_trigger();
        @(posedge clk); #2 trigger = 1'b1;
        @(posedge clk); #2 trigger = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 7; k++) dp[k] = 8'h00;
        #1 nreset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 nreset = 1'b1;

        // Idle after reset
        check("rst_tx",      {31'd0, tx}, 32'd1);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, frame_done}, 32'd0);
        check("rst_overrun", {24'd0, overrun_count}, 32'd0);
        repeat (50) @(posedge clk);

        // Basic frame
        for (int k = 0; k < 7; k++) dp[k] = 8'(k + 1);
        run_frame(1'b0);
        check_frame("frame1", 8'h01, 8'h01, 8'h1C);

        // Ports change right after acceptance
        for (int k = 0; k < 7; k++) dp[k] = 8'(k + 1);
        run_frame(1'b1);
        check_frame("snapshot", 8'h01, 8'h01, 8'h1C);

        // Triggers while busy are dropped and counted
        pulse_trigger();
        repeat (20) @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            pulse_trigger();
            repeat (10) @(posedge clk);
        end
        wait_idle("ovr3");
        check("overrun_3", {24'd0, overrun_count}, 32'h03);

        pulse_trigger();
        #0 trigger = 1'b1;
        repeat (300) @(posedge clk);
        #2 trigger = 1'b0;
        wait_idle("ovr_sat");
        check("overrun_sat", {24'd0, overrun_count}, 32'hFF);

        // Asynchronous reset mid-DATA of byte 4
        for (int k = 0; k < 7; k++) dp[k] = 8'h33;
        pulse_trigger();
        repeat (168) @(posedge clk);
        #2 check("pre_reset_busy", {31'd0, busy}, 32'd1);
        nreset = 1'b0;
        #1;
        check("async_rst_tx",      {31'd0, tx}, 32'd1);
        check("async_rst_busy",    {31'd0, busy}, 32'd0);
        check("async_rst_overrun", {24'd0, overrun_count}, 32'd0);
        repeat (3) @(posedge clk);
        #2 nreset = 1'b1;

        for (int k = 0; k < 7; k++) dp[k] = 8'((k + 1) * 16);
        run_frame(1'b0);
        check_frame("fresh", 8'h10, 8'h10, 8'hC0);

        // Trigger on the frame_done cycle is accepted with no gap
        pulse_trigger();
        begin
            int n;
            n = 0;
            @(posedge clk); #2;
            while (!frame_done && n < 1000) begin
                @(posedge clk); #2;
                n++;
            end
            check("b2b_found_done", {31'd0, frame_done}, 32'd1);
        end
        trigger = 1'b1;
        @(posedge clk); #2 trigger = 1'b0;
        check("b2b_start_bit", {31'd0, tx}, 32'd0);
        check("b2b_busy",      {31'd0, busy}, 32'd1);
        check("b2b_overrun",   {24'd0, overrun_count}, 32'd0);
        wait_idle("b2b");
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
